// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: a shared prescaler tick paces per-channel
// OFF / ON / BLINK / ONESHOT behaviour, configured through a one-cycle write port.
module led_blink_bank #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned PER_W          = 10,
  parameter int unsigned DEFAULT_PERIOD = 500,
  parameter int unsigned RESET_MODE     = 2,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [1:0]        WR_MODE,
  input  logic [PER_W-1:0]  WR_PERIOD,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] DONE,
  output logic              TICK
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_q, tick_d;
  mode_e             mode_q [NUM_CH];
  mode_e             mode_d [NUM_CH];
  logic [PER_W-1:0]  per_q  [NUM_CH];
  logic [PER_W-1:0]  per_d  [NUM_CH];
  logic [PER_W-1:0]  cnt_q  [NUM_CH];
  logic [PER_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              wr_ok;
  logic [PER_W-1:0]  wr_per;

  assign wr_ok  = WR_EN && (32'(WR_CH) < NUM_CH);
  assign wr_per = (WR_PERIOD == '0) ? PER_W'(1) : WR_PERIOD;

  // State registers; reset overrides any concurrent write.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
      done_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_e'(2'(RESET_MODE));
        per_q[i]  <= PER_W'(DEFAULT_PERIOD);
        cnt_q[i]  <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      done_q <= done_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        per_q[i]  <= per_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Prescaler and per-channel next state; a write to a channel masks its tick.
  always_comb begin
    tick_d = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d  = tick_d ? '0 : pre_q + PRE_W'(1);
    led_d  = led_q;
    done_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      per_d[i]  = per_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr_ok && (WR_CH == CH_W'(i))) begin
        mode_d[i] = mode_e'(WR_MODE);
        per_d[i]  = wr_per;
        cnt_d[i]  = '0;
        led_d[i]  = (mode_e'(WR_MODE) != MODE_OFF);
      end else if (tick_q) begin
        unique case (mode_q[i])
          MODE_OFF: led_d[i] = 1'b0;
          MODE_ON:  led_d[i] = 1'b1;
          MODE_BLINK: begin
            if (cnt_q[i] == per_q[i] - PER_W'(1)) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + PER_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q[i] == per_q[i] - PER_W'(1)) begin
              cnt_d[i]  = '0;
              led_d[i]  = 1'b0;
              mode_d[i] = MODE_OFF;
              done_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + PER_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign LED  = led_q;
  assign DONE = done_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_blink_bank.sv
// Scoreboard bench for led_blink_bank: a phase-based reference model queues the
// expected TICK/LED/DONE after each edge, a negedge monitor compares them.
module tb_led_blink_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned TDIV   = 4;
  localparam int unsigned PER_W  = 4;
  localparam int unsigned DPER   = 3;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [1:0]        wr_mode;
  logic [PER_W-1:0]  wr_period;
  logic [NUM_CH-1:0] led, done;
  logic              tick;

  led_blink_bank #(
    .NUM_CH(NUM_CH), .TICK_DIV(TDIV), .PER_W(PER_W),
    .DEFAULT_PERIOD(DPER), .RESET_MODE(2)
  ) dut (
    .CLK100MHZ(clk), .RST(rst), .WR_EN(wr_en), .WR_CH(wr_ch),
    .WR_MODE(wr_mode), .WR_PERIOD(wr_period),
    .LED(led), .DONE(done), .TICK(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              tick;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] done;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: each channel remembers its starting LED level and how many
  // ticks have elapsed since its phase began; the LED level follows from that.
  bit                m_valid = 0;
  int                since;
  bit                m_tick;
  int                m_mode [NUM_CH];
  int                m_per  [NUM_CH];
  int                m_ph   [NUM_CH];
  bit                m_led0 [NUM_CH];
  logic [NUM_CH-1:0] m_led, m_done;

  always @(posedge clk) begin
    bit tick_in;
    if (rst) begin
      m_valid = 1;
      since   = 0;
      m_tick  = 0;
      m_led   = '0;
      m_done  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = 2; m_per[i] = DPER; m_ph[i] = 0; m_led0[i] = 0;
      end
    end else if (m_valid) begin
      tick_in = m_tick;
      m_done  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && int'(wr_ch) == i) begin
          m_mode[i] = int'(wr_mode);
          m_per[i]  = (wr_period == 0) ? 1 : int'(wr_period);
          m_ph[i]   = 0;
          m_led0[i] = (wr_mode != 2'd0);
          m_led[i]  = m_led0[i];
        end else if (tick_in) begin
          if (m_mode[i] == 0) m_led[i] = 1'b0;
          else if (m_mode[i] == 1) m_led[i] = 1'b1;
          else if (m_mode[i] == 2) begin
            m_ph[i]  = (m_ph[i] + 1) % (2 * m_per[i]);
            m_led[i] = m_led0[i] ^ ((m_ph[i] / m_per[i]) % 2 == 1);
          end else begin
            m_ph[i] = m_ph[i] + 1;
            if (m_ph[i] >= m_per[i]) begin
              m_led[i]  = 1'b0;
              m_done[i] = 1'b1;
              m_mode[i] = 0;
              m_ph[i]   = 0;
            end
          end
        end
      end
      since  = since + 1;
      m_tick = (since % TDIV == 0);
    end
    if (m_valid) exp_q.push_back({m_tick, m_led, m_done});
  end

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tick, led, done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL obs cyc=%0d got tick=%b led=%b done=%b want tick=%b led=%b done=%b",
                 cyc, a.tick, a.led, a.done, e.tick, e.led, e.done);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input int ch, input int mode, input int per);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_mode = 2'(mode); wr_period = PER_W'(per);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic sync_tick();
    int n;
    n = 0;
    while (!m_tick && n < 2 * TDIV) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_tick) begin
      errors++;
      $display("FAIL sync_tick got no tick within %0d cycles want tick", 2 * TDIV);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_period = '0;
    idle(2);
    rst = 1'b0;
    // Reset release, free-running BLINK.
    idle(30);
    // ONESHOT on ch1, period 2.
    wr(1, 3, 2);
    idle(16);
    // ch0 ON, ch2 OFF, then a write to an absent channel.
    wr(0, 1, 5);
    wr(2, 0, 5);
    idle(80);
    wr(3, 1, 1);
    idle(8);
    // BLINK with period 0 written on a tick cycle.
    sync_tick();
    wr(2, 2, 0);
    idle(20);
    // ONESHOT retrigger after two ticks.
    wr(1, 3, 4);
    idle(2 * TDIV);
    wr(1, 3, 4);
    idle(24);
    // Reset during an active ONESHOT, with a concurrent write.
    wr(1, 3, 5);
    idle(6);
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_mode = 2'd1; wr_period = 4'd2;
    idle(1);
    rst = 1'b0; wr_en = 1'b0;
    idle(30);
    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      rst   = ($urandom_range(0, 149) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_ch = CH_W'($urandom_range(0, 3));
      wr_mode = 2'($urandom_range(0, 3));
      wr_period = ($urandom_range(0, 3) == 0) ? PER_W'($urandom_range(0, 15))
                                              : PER_W'($urandom_range(0, 4));
      idle(1);
    end
    rst = 1'b0; wr_en = 1'b0;
    idle(3);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL drain got %0d pending want <=1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
